// File: rtl/whack_game_controller.sv
// Whack-a-mole sequencer: LFSR mole choice, per-window and per-game second timers, hit pulses.
// All outputs registered one cycle after the deciding edge; no backpressure, inputs sampled every cycle.
module whack_game_controller #(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned GAME_SECONDS = 30,
    parameter int unsigned MOLE_TICKS   = 2,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       Resetn,
    input  logic       start,
    input  logic [3:0] keys,
    input  logic       enable_control,
    input  logic       timer_done,
    output logic [2:0] state,
    output logic       player_signal,
    output logic       timer_signal,
    output logic [3:0] mole_onehot,
    output logic [5:0] seconds_left,
    output logic       busy
);

    localparam int unsigned    DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [5:0]     SEC_INIT = 6'(GAME_SECONDS);
    localparam logic [3:0]     WIN_LAST = 4'(MOLE_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_START = 3'b001,
        ST_MOLE0 = 3'b010,
        ST_MOLE1 = 3'b011,
        ST_MOLE2 = 3'b100,
        ST_MOLE3 = 3'b101,
        ST_END   = 3'b110
    } state_t;

    state_t             state_q, state_d;
    logic               start_d;
    logic [3:0]         keys_d;
    logic [DIV_W-1:0]   div_q;
    logic [3:0]         win_cnt;
    logic               hit_flag;
    logic [7:0]         lfsr;

    logic               start_rise;
    logic [3:0]         key_rise;
    logic               in_mole, timing, tick, hit, win_exp, game_exp;
    logic               next_mole, hit_flag_d;
    logic [1:0]         cur_idx, pick_idx, next_idx, nxt_state_idx;

    function automatic state_t mole_state(input logic [1:0] idx);
        return state_t'({1'b0, idx} + 3'd2);
    endfunction

    always_comb begin
        start_rise = start & ~start_d;
        key_rise   = keys & ~keys_d;
        in_mole    = (state_q >= ST_MOLE0) && (state_q <= ST_MOLE3);
        timing     = in_mole || (state_q == ST_START);
        tick       = timing && (div_q == DIV_LAST);
        cur_idx    = 2'(3'(state_q) - 3'd2);
        pick_idx   = lfsr[1:0];
        // Never raise the same hole twice in a row.
        next_idx   = (pick_idx == cur_idx) ? cur_idx + 2'd1 : pick_idx;
        hit        = in_mole && !hit_flag && key_rise[cur_idx];
        win_exp    = in_mole && tick && (win_cnt == WIN_LAST);
        game_exp   = in_mole && tick && (seconds_left == 6'd1);

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_rise) state_d = ST_START;
            ST_START: if (enable_control) state_d = mole_state(pick_idx);
            ST_MOLE0, ST_MOLE1, ST_MOLE2, ST_MOLE3: begin
                if (timer_done || game_exp) state_d = ST_END;
                else if (win_exp)           state_d = mole_state(next_idx);
            end
            ST_END:   if (start_rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        next_mole     = (state_d >= ST_MOLE0) && (state_d <= ST_MOLE3);
        nxt_state_idx = 2'(3'(state_d) - 3'd2);
        hit_flag_d    = (in_mole && next_mole && !win_exp) ? (hit_flag | hit) : 1'b0;
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    assign state = state_q;

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            // start_d resets high so a key held through reset is not taken as a press.
            start_d       <= 1'b1;
            keys_d        <= 4'h0;
            div_q         <= '0;
            win_cnt       <= 4'h0;
            hit_flag      <= 1'b0;
            lfsr          <= LFSR_SEED;
            seconds_left  <= SEC_INIT;
            player_signal <= 1'b0;
            timer_signal  <= 1'b0;
            mole_onehot   <= 4'h0;
            busy          <= 1'b0;
        end else begin
            start_d       <= start;
            keys_d        <= keys;
            player_signal <= hit;
            timer_signal  <= game_exp;
            hit_flag      <= hit_flag_d;
            busy          <= (state_d != ST_IDLE) && (state_d != ST_END);
            mole_onehot   <= (next_mole && !hit_flag_d) ? (4'b0001 << nxt_state_idx) : 4'h0;

            if (timing)
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

            if (state_q == ST_IDLE && start_rise)
                div_q <= '0;
            else if (timing)
                div_q <= tick ? '0 : div_q + 1'b1;

            if (state_q == ST_IDLE && start_rise)
                seconds_left <= SEC_INIT;
            else if (in_mole && tick && seconds_left != 6'd0)
                seconds_left <= seconds_left - 6'd1;

            if (!in_mole || win_exp)
                win_cnt <= 4'h0;
            else if (tick)
                win_cnt <= win_cnt + 4'h1;
        end
    end

endmodule

// File: tb/tb_whack_game_controller.sv
// Scoreboarded directed bench for whack_game_controller (TICK_DIV=4, GAME_SECONDS=3, MOLE_TICKS=1).
module tb_whack_game_controller;

    logic       clk = 1'b0;
    logic       Resetn;
    logic       start;
    logic [3:0] keys;
    logic       enable_control;
    logic       timer_done;
    logic [2:0] state;
    logic       player_signal;
    logic       timer_signal;
    logic [3:0] mole_onehot;
    logic [5:0] seconds_left;
    logic       busy;

    whack_game_controller #(
        .TICK_DIV(4), .GAME_SECONDS(3), .MOLE_TICKS(1), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .Resetn(Resetn), .start(start), .keys(keys),
        .enable_control(enable_control), .timer_done(timer_done),
        .state(state), .player_signal(player_signal), .timer_signal(timer_signal),
        .mole_onehot(mole_onehot), .seconds_left(seconds_left), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [2:0] st;
        logic       ps;
        logic       ts;
        logic [3:0] mo;
        logic [5:0] sec;
        logic       bz;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam int S_IDLE = 0, S_START = 1, S_M1 = 3, S_M2 = 4, S_M3 = 5, S_END = 6;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic push_exp(input int tag, input int es, input int ep, input int et,
                            input int em, input int esec, input int eb);
        exp_t e;
        e.tag = tag; e.st = 3'(es); e.ps = 1'(ep); e.ts = 1'(et);
        e.mo = 4'(em); e.sec = 6'(esec); e.bz = 1'(eb);
        q.push_back(e);
    endtask

    // Inputs set here are seen by the next rising edge; expectation is for the state after it.
    task automatic step(input int st, input int k, input int en, input int td,
                        input int es, input int ep, input int et, input int em,
                        input int esec, input int eb);
        @(negedge clk);
        start = 1'(st); keys = 4'(k); enable_control = 1'(en); timer_done = 1'(td);
        push_exp(cyc + 1, es, ep, et, em, esec, eb);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        Resetn = 1'b0; start = 1'b0; keys = 4'h0; enable_control = 1'b0; timer_done = 1'b0;
        push_exp(cyc + 1, S_IDLE, 0, 0, 0, 3, 0);
        @(negedge clk);
        Resetn = 1'b1;
        push_exp(cyc + 1, S_IDLE, 0, 0, 0, 3, 0);
    endtask

    task automatic chk(input string nm, input int tag, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, tag, act, expv);
        end
    endtask

    initial forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].tag <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.tag < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missed_sample @cycle %0d: got none, expected sample", e.tag);
            end else begin
                chk("state",         e.tag, 8'(state),         8'(e.st));
                chk("player_signal", e.tag, 8'(player_signal), 8'(e.ps));
                chk("timer_signal",  e.tag, 8'(timer_signal),  8'(e.ts));
                chk("mole_onehot",   e.tag, 8'(mole_onehot),   8'(e.mo));
                chk("seconds_left",  e.tag, 8'(seconds_left),  8'(e.sec));
                chk("busy",          e.tag, 8'(busy),          8'(e.bz));
            end
        end
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        Resetn = 1'b0; start = 1'b0; keys = 4'h0; enable_control = 1'b0; timer_done = 1'b0;

        // Free-running game: moles 1 -> 2 -> 3, timer expires after 12 edges.
        apply_reset();
        step(1, 0, 1, 0, S_START, 0, 0, 0, 3, 1);
        repeat (3) step(0, 0, 1, 0, S_M1, 0, 0, 4'h2, 3, 1);
        repeat (4) step(0, 0, 1, 0, S_M2, 0, 0, 4'h4, 2, 1);
        repeat (4) step(0, 0, 1, 0, S_M3, 0, 0, 4'h8, 1, 1);
        step(0, 0, 1, 0, S_END, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, S_END, 0, 0, 0, 0, 0);

        // Hits: valid, repeated, wrong hole, and coincident with game expiry.
        apply_reset();
        step(1, 0,    1, 0, S_START, 0, 0, 0,    3, 1);
        step(0, 0,    1, 0, S_M1,    0, 0, 4'h2, 3, 1);
        step(0, 4'h2, 1, 0, S_M1,    1, 0, 0,    3, 1);
        step(0, 0,    1, 0, S_M1,    0, 0, 0,    3, 1);
        step(0, 4'h2, 1, 0, S_M2,    0, 0, 4'h4, 2, 1);
        step(0, 0,    1, 0, S_M2,    0, 0, 4'h4, 2, 1);
        step(0, 4'h8, 1, 0, S_M2,    0, 0, 4'h4, 2, 1);
        step(0, 0,    1, 0, S_M2,    0, 0, 4'h4, 2, 1);
        repeat (4) step(0, 0, 1, 0, S_M3, 0, 0, 4'h8, 1, 1);
        step(0, 4'h8, 1, 0, S_END,   1, 1, 0,    0, 0);
        step(0, 0,    1, 0, S_END,   0, 0, 0,    0, 0);

        // timer_done aborts the game without timer_signal, then start returns to IDLE.
        apply_reset();
        step(1, 0, 1, 0, S_START, 0, 0, 0, 3, 1);
        repeat (3) step(0, 0, 1, 0, S_M1, 0, 0, 4'h2, 3, 1);
        step(0, 0, 1, 0, S_M2,  0, 0, 4'h4, 2, 1);
        step(0, 0, 1, 1, S_END, 0, 0, 0,    2, 0);
        step(0, 0, 1, 0, S_END, 0, 0, 0,    2, 0);
        step(1, 0, 1, 0, S_IDLE, 0, 0, 0,   2, 0);
        step(0, 0, 1, 0, S_IDLE, 0, 0, 0,   2, 0);

        // Asynchronous reset mid-window, start held high through release.
        apply_reset();
        step(1, 0, 1, 0, S_START, 0, 0, 0, 3, 1);
        repeat (3) step(0, 0, 1, 0, S_M1, 0, 0, 4'h2, 3, 1);
        step(0, 0, 1, 0, S_M2, 0, 0, 4'h4, 2, 1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        Resetn = 1'b0;
        start  = 1'b1;
        push_exp(cyc, S_IDLE, 0, 0, 0, 3, 0);
        @(negedge clk);
        Resetn = 1'b1;
        push_exp(cyc + 1, S_IDLE, 0, 0, 0, 3, 0);
        step(1, 0, 0, 0, S_IDLE,  0, 0, 0, 3, 0);
        step(0, 0, 0, 0, S_IDLE,  0, 0, 0, 3, 0);
        step(1, 0, 0, 0, S_START, 0, 0, 0, 3, 1);
        step(0, 0, 0, 0, S_START, 0, 0, 0, 3, 1);

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/whack_game_controller.md
Name: whack_game_controller

Overview:
- Top-level sequencer for the whack-a-mole game. It drives the 3-bit game `state` consumed by the score datapath and generates the per-hit `player_signal` and end-of-game `timer_signal`.
- It chooses mole positions with an LFSR, times each mole window and the overall game, and debounces nothing: keys arrive already synchronised.
- It sits between the key/switch inputs and the score datapath, and shares the datapath's clock.

Parameters:
- TICK_DIV, 50000000, clk cycles per game second
- GAME_SECONDS, 30, game length in seconds (1..63)
- MOLE_TICKS, 2, seconds a mole window lasts (1..15)
- LFSR_SEED, 8'hA5, non-zero LFSR reset value

Ports:
- clk  input  1  system clock, all logic on posedge
- Resetn  input  1  asynchronous active-low reset
- start  input  1  start/restart key, level, synchronised
- keys  input  4  hit keys, one per hole, active-high, synchronised
- enable_control  input  1  datapath ready/toggle indication
- timer_done  input  1  datapath end-of-game flag
- state  output  3  game state to datapath
- player_signal  output  1  one-cycle pulse per valid hit
- timer_signal  output  1  one-cycle pulse when the game timer expires
- mole_onehot  output  4  raised mole, to display
- seconds_left  output  6  remaining game seconds, to display
- busy  output  1  high in every state except IDLE and END

Behaviour:
Reset:
- Resetn low asynchronously forces: state=IDLE, all pulses 0, mole_onehot=0, seconds_left=GAME_SECONDS, busy=0, lfsr=LFSR_SEED, all counters 0.
- Reset mid-game aborts immediately; no pulse is emitted.

State encoding (fixed, datapath depends on it):
- IDLE=000, START=001, MOLE0..MOLE3=010..101 (mole index k = state-2), END=110.

Transitions:
- IDLE: on rising edge of start (start=1, start_d=0) -> START. Clear the tick divider and set seconds_left=GAME_SECONDS.
- START: stay until enable_control=1, then -> MOLE(lfsr[1:0]). Start is ignored while in START.
- MOLEk:
  - mole_onehot = 1<<k until hit, then 0 for the rest of the window.
  - Valid hit: rising edge of keys[k] with hit_flag=0. Response is player_signal=1 for exactly one cycle and hit_flag<=1.
  - Edges on other keys are ignored. At most one hit counts per window.
  - Window expiry: after MOLE_TICKS second-ticks in this window -> next mole. Next index n = lfsr[1:0]; if n==k use (k+1) mod 4. Clear hit_flag and the window counter.
- END: mole_onehot=0. On rising edge of start -> IDLE.

Tick and game timer:
- Tick divider runs 0..TICK_DIV-1 in START/MOLEx; tick is 1 on the TICK_DIV-1 cycle.
- In MOLEx each tick decrements seconds_left. When seconds_left goes 1->0: timer_signal=1 for that cycle and state -> END on the same edge.
- timer_done=1 in any MOLEx also forces END, with no timer_signal.

LFSR:
- 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Advances every clock while busy; holds otherwise.
- It never reaches 0 from a non-zero seed.

Simultaneous events:
- Hit and window expiry in the same cycle: the hit counts (pulse), then the new mole.
- Hit and game expiry in the same cycle: player_signal and timer_signal both pulse; next state END.
- Window expiry and game expiry in the same cycle: END wins.

Widths:
- seconds_left saturates at 0.
- Window counter is 4 bits.
- No output changes combinationally from inputs; all outputs are registered.

Test Plan:
Bench settings: TICK_DIV=4, GAME_SECONDS=3, MOLE_TICKS=1, LFSR_SEED=8'hA5.
- Release reset, pulse start 1 cycle, hold enable_control=1 -> state 000->001->(010..101) on successive edges; busy=1; seconds_left=3.
- In MOLEk, pulse keys[k] once -> exactly one 1-cycle player_signal, mole_onehot=0. Second pulse of keys[k] in the same window -> no pulse. Pulse keys[(k+1)%4] -> no pulse.
- No keys pressed -> mole changes every 4 cycles, never to the same index twice in a row; after 12 cycles timer_signal pulses once, state=110, seconds_left=0.
- Hit edge coincident with the final tick -> player_signal and timer_signal both 1 in that cycle; next state 110.
- Assert timer_done mid-game -> state 110 next edge, timer_signal stays 0. Then pulse start -> state 000.
- Drop Resetn asynchronously mid-window with mole up -> state=000, mole_onehot=0, seconds_left=3 with no clock edge; hold start high through reset release -> no transition until start falls and rises again.
